// File: rtl/halt_ctrl_pkg.sv
// Shared encodings for the pipeline halt/stall controller: host request codes,
// FSM states and the per-stage stall masks.
package halt_ctrl_pkg;

  localparam logic [1:0] HALT_RUN  = 2'b00;
  localparam logic [1:0] HALT_STEP = 2'b01;
  localparam logic [1:0] HALT_STOP = 2'b11;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED,
    ST_STEP,
    ST_STEP_DRAIN
  } state_t;

  // bit 0 = PC ... bit 5 = WB; a stage stall also holds every younger stage
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  function automatic logic [5:0] base_stall(input logic req_mem, input logic req_ex,
                                            input logic req_id, input logic req_if);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/halt_ctrl_if.sv
// Host request, per-stage stall requests and stall/halt status of the core.
interface halt_ctrl_if;
  logic [1:0] halt_req;
  logic       stallreq_if;
  logic       stallreq_id;
  logic       stallreq_ex;
  logic       stallreq_mem;
  logic       pipe_busy;
  logic [5:0] stall;
  logic       halted;
  logic       step_done;

  modport master (
    output halt_req, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, pipe_busy,
    input  stall, halted, step_done
  );

  modport slave (
    input  halt_req, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, pipe_busy,
    output stall, halted, step_done
  );
endinterface

// File: rtl/halt_ctrl_sync.sv
// Multi-flop synchronizer for an asynchronous bus, cleared to zero on reset.
module halt_sync #(
  parameter int W      = 2,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] sync_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[STAGES-2:0], d};
  end

  assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/halt_ctrl.sv
// Stall/halt controller: drains the pipeline on a host halt, single-steps one
// fetch on an 11->01 request edge, and muxes the per-stage stall vector.
module halt_ctrl
  import halt_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  halt_ctrl_if.slave   bus
);

  logic [1:0] hr, hr_prev;
  state_t     state, state_nx;
  logic [5:0] base, stall_nx;
  logic       idle;
  logic       halted_q, step_q;

  halt_sync #(.W(2), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.halt_req),
    .q   (hr)
  );

  assign base = base_stall(bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if);
  assign idle = !bus.pipe_busy && (base == STALL_NONE);

  // hr[0] separates halt-like requests (11, 01) from run requests (00, 10)
  always_comb begin
    state_nx = state;
    stall_nx = base;
    unique case (state)
      ST_RUN: begin
        if (hr[0]) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall_nx = base | STALL_IF;
        if (!hr[0])    state_nx = ST_RUN;
        else if (idle) state_nx = ST_HALTED;
      end
      ST_HALTED: begin
        stall_nx = STALL_ALL;
        if (!hr[0])                                     state_nx = ST_RUN;
        else if (hr == HALT_STEP && hr_prev == HALT_STOP) state_nx = ST_STEP;
      end
      ST_STEP: begin
        if (base == STALL_NONE) state_nx = ST_STEP_DRAIN;
      end
      ST_STEP_DRAIN: begin
        // a started step always completes; run requests wait for HALTED
        stall_nx = base | STALL_IF;
        if (idle) state_nx = ST_HALTED;
      end
      default: begin
        state_nx = ST_RUN;
        stall_nx = STALL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      hr_prev  <= HALT_RUN;
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      hr_prev  <= hr;
      halted_q <= (state_nx == ST_HALTED);
      step_q   <= (state == ST_STEP_DRAIN) && (state_nx == ST_HALTED);
    end
  end

  assign bus.stall     = stall_nx;
  assign bus.halted    = halted_q;
  assign bus.step_done = step_q;

endmodule
